// File: rtl/multicycle_ctrl_fsm_pkg.sv
// rtl/multicycle_ctrl_fsm_pkg.sv - states, instruction classes, opcode and ALU-op constants
// Shared by the sequencer, its opcode classifier and the memory-port interface users.
package multicycle_ctrl_fsm_pkg;

  typedef enum logic [2:0] {
    S_RST    = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_e;

  typedef enum logic [2:0] {
    CLS_NONE = 3'd0,
    CLS_R    = 3'd1,
    CLS_I    = 3'd2,
    CLS_L    = 3'd3,
    CLS_S    = 3'd4,
    CLS_B    = 3'd5
  } cls_e;

  localparam logic [6:0] OPC_R = 7'b0110011;
  localparam logic [6:0] OPC_I = 7'b0010011;
  localparam logic [6:0] OPC_L = 7'b0000011;
  localparam logic [6:0] OPC_S = 7'b0100011;
  localparam logic [6:0] OPC_B = 7'b1100011;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

endpackage

// File: rtl/multicycle_ctrl_fsm_if.sv
// rtl/multicycle_ctrl_fsm_if.sv - shared instruction/data memory port, req/ack handshake
// The sequencer is the master; the memory holds mem_ack for the completing cycle only.
interface multicycle_ctrl_fsm_if;
  logic mem_req;
  logic mem_we;
  logic mem_sel;
  logic mem_ack;

  modport master (output mem_req, output mem_we, output mem_sel, input mem_ack);
  modport slave  (input mem_req, input mem_we, input mem_sel, output mem_ack);
endinterface

// File: rtl/ctrl_opcode_classify.sv
// rtl/ctrl_opcode_classify.sv - combinational RV32I opcode to instruction class decode
// Anything outside the five supported major opcodes maps to CLS_NONE (illegal).
module ctrl_opcode_classify
  import multicycle_ctrl_fsm_pkg::*;
(
  input  logic [6:0] opcode,
  output cls_e       cls
);

  always_comb begin
    cls = CLS_NONE;
    case (opcode)
      OPC_R:   cls = CLS_R;
      OPC_I:   cls = CLS_I;
      OPC_L:   cls = CLS_L;
      OPC_S:   cls = CLS_S;
      OPC_B:   cls = CLS_B;
      default: cls = CLS_NONE;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// rtl/multicycle_ctrl_fsm.sv - FETCH/DECODE/EXEC/MEM/WB sequencer for a multi-cycle RV32I datapath
// Optional retired-instruction counter enabled by CTRL_PERF_CNT_EN.
module multicycle_ctrl_fsm
  import multicycle_ctrl_fsm_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int TO_W        = 8,
  parameter int CNT_W       = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [6:0]              opcode,
  input  logic                    alu_zero,
  multicycle_ctrl_fsm_if.master   mem,
  output logic                    ir_we,
  output logic                    mdr_we,
  output logic                    pc_we,
  output logic                    pc_src,
  output logic                    alu_src,
  output logic [1:0]              alu_op,
  output logic                    reg_we,
  output logic                    mem_to_reg,
  output logic                    halted,
  output logic                    bus_err
`ifdef CTRL_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]        instret
`endif
);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

  state_e          r_state;
  state_e          w_next;
  cls_e            r_cls;
  cls_e            w_cls;
  logic [TO_W-1:0] r_to_cnt;
  logic            r_halted;
  logic            r_bus_err;
  logic            w_to_last;
  logic            w_timeout;
  logic            w_retire;

  ctrl_opcode_classify u_classify (
    .opcode (opcode),
    .cls    (w_cls)
  );

  // The cycle that would be the MEM_TIMEOUT-th unacknowledged request cycle.
  assign w_to_last = (MEM_TIMEOUT != 0) && (r_to_cnt == TO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_RST;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_timeout   = 1'b0;
    w_retire    = 1'b0;
    mem.mem_req = 1'b0;
    mem.mem_we  = 1'b0;
    mem.mem_sel = 1'b0;
    ir_we       = 1'b0;
    mdr_we      = 1'b0;
    pc_we       = 1'b0;
    pc_src      = 1'b0;
    alu_src     = 1'b0;
    alu_op      = ALU_OP_ADD;
    reg_we      = 1'b0;
    mem_to_reg  = 1'b0;
    case (r_state)
      S_RST: w_next = S_FETCH;
      S_FETCH: begin
        mem.mem_req = 1'b1;
        if (mem.mem_ack) begin
          ir_we  = 1'b1;
          pc_we  = 1'b1;
          w_next = S_DECODE;
        end else if (w_to_last) begin
          w_timeout = 1'b1;
          w_next    = S_HALT;
        end
      end
      S_DECODE: w_next = (w_cls == CLS_NONE) ? S_HALT : S_EXEC;
      S_EXEC: begin
        alu_src = (r_cls == CLS_I) || (r_cls == CLS_L) || (r_cls == CLS_S);
        case (r_cls)
          CLS_R, CLS_I: begin
            alu_op = ALU_OP_FUNCT;
            w_next = S_WB;
          end
          CLS_L, CLS_S: w_next = S_MEM;
          CLS_B: begin
            alu_op   = ALU_OP_SUB;
            pc_src   = 1'b1;
            pc_we    = alu_zero;
            w_retire = 1'b1;
            w_next   = S_FETCH;
          end
          default: w_next = S_HALT;
        endcase
      end
      S_MEM: begin
        mem.mem_req = 1'b1;
        mem.mem_sel = 1'b1;
        mem.mem_we  = (r_cls == CLS_S);
        if (mem.mem_ack) begin
          if (r_cls == CLS_S) begin
            w_retire = 1'b1;
            w_next   = S_FETCH;
          end else begin
            mdr_we = 1'b1;
            w_next = S_WB;
          end
        end else if (w_to_last) begin
          w_timeout = 1'b1;
          w_next    = S_HALT;
        end
      end
      S_WB: begin
        reg_we     = 1'b1;
        mem_to_reg = (r_cls == CLS_L);
        w_retire   = 1'b1;
        w_next     = S_FETCH;
      end
      S_HALT: w_next = S_HALT;
      default: w_next = S_RST;
    endcase
  end

  // Class is captured once per instruction; the timeout count restarts on every state change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cls     <= CLS_NONE;
      r_to_cnt  <= '0;
      r_halted  <= 1'b0;
      r_bus_err <= 1'b0;
    end else begin
      if (r_state == S_DECODE) begin
        r_cls <= w_cls;
      end
      if (w_next != r_state) begin
        r_to_cnt <= '0;
      end else if (mem.mem_req && !mem.mem_ack) begin
        r_to_cnt <= r_to_cnt + TO_W'(1);
      end
      if ((w_next == S_HALT) && (r_state != S_HALT)) begin
        r_halted <= 1'b1;
      end
      if (w_timeout) begin
        r_bus_err <= 1'b1;
      end
    end
  end

  assign halted  = r_halted;
  assign bus_err = r_bus_err;

`ifdef CTRL_PERF_CNT_EN
  logic [CNT_W-1:0] r_instret;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instret <= '0;
    end else if (w_retire) begin
      r_instret <= r_instret + CNT_W'(1);
    end
  end

  assign instret = r_instret;
`else
  logic [CNT_W:0] w_unused_perf;
  assign w_unused_perf = {w_retire, {CNT_W{1'b0}}};
`endif

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// tb/tb_multicycle_ctrl_fsm.sv - directed table, random instruction stream and corner sequences
// Expected per-cycle outputs come from an instruction-level schedule model (CTRL_PERF_CNT_EN adds instret checks).
module tb_multicycle_ctrl_fsm;

  localparam int TO = 4;

  localparam logic [13:0] B_REQ    = 14'h2000;
  localparam logic [13:0] B_WE     = 14'h1000;
  localparam logic [13:0] B_SEL    = 14'h0800;
  localparam logic [13:0] B_IR     = 14'h0400;
  localparam logic [13:0] B_MDR    = 14'h0200;
  localparam logic [13:0] B_PCWE   = 14'h0100;
  localparam logic [13:0] B_PCSRC  = 14'h0080;
  localparam logic [13:0] B_ALUSRC = 14'h0040;
  localparam logic [13:0] B_OPFN   = 14'h0020;
  localparam logic [13:0] B_OPSUB  = 14'h0010;
  localparam logic [13:0] B_REGWE  = 14'h0008;
  localparam logic [13:0] B_M2R    = 14'h0004;
  localparam logic [13:0] B_HALT   = 14'h0002;
  localparam logic [13:0] B_BERR   = 14'h0001;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] opcode;
  logic       alu_zero;
  logic       ir_we, mdr_we, pc_we, pc_src, alu_src, reg_we, mem_to_reg, halted, bus_err;
  logic [1:0] alu_op;
`ifdef CTRL_PERF_CNT_EN
  logic [31:0] instret;
`endif

  multicycle_ctrl_fsm_if bus ();

  multicycle_ctrl_fsm #(.MEM_TIMEOUT(TO), .TO_W(8), .CNT_W(32)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .alu_zero   (alu_zero),
    .mem        (bus),
    .ir_we      (ir_we),
    .mdr_we     (mdr_we),
    .pc_we      (pc_we),
    .pc_src     (pc_src),
    .alu_src    (alu_src),
    .alu_op     (alu_op),
    .reg_we     (reg_we),
    .mem_to_reg (mem_to_reg),
    .halted     (halted),
    .bus_err    (bus_err)
`ifdef CTRL_PERF_CNT_EN
    ,
    .instret    (instret)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] opc;
    int         wf;
    int         wm;
    logic       z;
    int         exp_regwe;
    int         exp_pcwe;
    int         exp_mdrwe;
  } vec_t;

  int n_chk = 0;
  int n_err = 0;
  int s_regwe, s_pcwe, s_mdrwe;
  int model_instret = 0;

  function automatic logic [13:0] dut_vec();
    return {bus.mem_req, bus.mem_we, bus.mem_sel, ir_we, mdr_we, pc_we, pc_src,
            alu_src, alu_op, reg_we, mem_to_reg, halted, bus_err};
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic byte kind_of(input logic [6:0] o);
    case (o)
      7'b0110011: return "R";
      7'b0010011: return "I";
      7'b0000011: return "L";
      7'b0100011: return "S";
      7'b1100011: return "B";
      default:    return "X";
    endcase
  endfunction

  task automatic chk_vec(input logic [13:0] act, input logic [13:0] exp, input string name);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s t=%0t outputs=%h required=%h", name, $time, act, exp);
    end
  endtask

  task automatic chk_int(input longint act, input longint exp, input string name);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s t=%0t got=%0d required=%0d", name, $time, act, exp);
    end
  endtask

  // Called at posedge+1; drives one cycle of inputs and checks outputs at the falling edge.
  task automatic step(input logic ack, input logic [6:0] opc, input logic z,
                      input logic [13:0] exp, input string name);
    bus.mem_ack = ack;
    opcode      = opc;
    alu_zero    = z;
    @(negedge clk);
    chk_vec(dut_vec(), exp, name);
    s_regwe += int'(reg_we);
    s_pcwe  += int'(pc_we);
    s_mdrwe += int'(mdr_we);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    bus.mem_ack = 1'b0;
    opcode      = '0;
    alu_zero    = 1'b0;
    @(negedge clk);
    chk_vec(dut_vec(), 14'h0, "in_reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_instret = 0;
    step(rbit(), 7'($urandom), rbit(), 14'h0, "rst_state");
  endtask

  // One instruction as a schedule: fetch wait, decode, exec, optional mem wait, optional writeback.
  task automatic run_instr(input logic [6:0] opc, input int wf, input int wm, input logic z);
    byte k;
    logic [13:0] e;
    k = kind_of(opc);
    s_regwe = 0;
    s_pcwe  = 0;
    s_mdrwe = 0;
    for (int i = 0; i <= wf; i++)
      step(i == wf, 7'($urandom), rbit(), (i == wf) ? (B_REQ | B_IR | B_PCWE) : B_REQ, "fetch");
    step(rbit(), opc, rbit(), 14'h0, "decode");
    if (k == "X") return;
    e = 14'h0;
    if (k == "I" || k == "L" || k == "S") e |= B_ALUSRC;
    if (k == "R" || k == "I") e |= B_OPFN;
    if (k == "B") e |= B_OPSUB | B_PCSRC | (z ? B_PCWE : 14'h0);
    step(rbit(), 7'($urandom), (k == "B") ? z : rbit(), e, "exec");
    if (k == "L" || k == "S") begin
      for (int i = 0; i <= wm; i++) begin
        e = B_REQ | B_SEL | ((k == "S") ? B_WE : 14'h0) | ((i == wm && k == "L") ? B_MDR : 14'h0);
        step(i == wm, 7'($urandom), rbit(), e, "mem");
      end
    end
    if (k == "R" || k == "I" || k == "L")
      step(rbit(), 7'($urandom), rbit(), B_REGWE | ((k == "L") ? B_M2R : 14'h0), "wb");
    model_instret++;
  endtask

  vec_t tbl[9];
  logic [6:0] legal[5];

  initial begin
    tbl[0] = '{7'b0010011, 0, 0, 1'b0, 1, 1, 0};
    tbl[1] = '{7'b0110011, 1, 0, 1'b1, 1, 1, 0};
    tbl[2] = '{7'b0000011, 0, 2, 1'b0, 1, 1, 1};
    tbl[3] = '{7'b0100011, 2, 1, 1'b0, 0, 1, 0};
    tbl[4] = '{7'b1100011, 0, 0, 1'b1, 0, 2, 0};
    tbl[5] = '{7'b1100011, 0, 0, 1'b0, 0, 1, 0};
    tbl[6] = '{7'b0010011, 3, 0, 1'b0, 1, 1, 0};
    tbl[7] = '{7'b0000011, 1, 3, 1'b1, 1, 1, 1};
    tbl[8] = '{7'b0100011, 0, 3, 1'b0, 0, 1, 0};
    legal  = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011};

    do_reset();
    for (int i = 0; i < 9; i++) begin
      run_instr(tbl[i].opc, tbl[i].wf, tbl[i].wm, tbl[i].z);
      chk_int(s_regwe, tbl[i].exp_regwe, $sformatf("tbl%0d_reg_we_cycles", i));
      chk_int(s_pcwe,  tbl[i].exp_pcwe,  $sformatf("tbl%0d_pc_we_cycles", i));
      chk_int(s_mdrwe, tbl[i].exp_mdrwe, $sformatf("tbl%0d_mdr_we_cycles", i));
`ifdef CTRL_PERF_CNT_EN
      if (i == 0) chk_int(instret, 1, "instret_after_addi");
`endif
    end

    for (int n = 0; n < 60; n++)
      run_instr(legal[$urandom_range(0, 4)], $urandom_range(0, TO - 1), $urandom_range(0, TO - 1), rbit());
`ifdef CTRL_PERF_CNT_EN
    chk_int(instret, model_instret, "instret_random");
`endif

    run_instr(7'b1111111, 0, 0, 1'b0);
    for (int i = 0; i < 20; i++)
      step(rbit(), 7'($urandom), rbit(), B_HALT, "illegal_halt");
`ifdef CTRL_PERF_CNT_EN
    chk_int(instret, model_instret, "instret_held_in_halt");
`endif

    do_reset();
    for (int i = 0; i < TO; i++)
      step(1'b0, 7'($urandom), rbit(), B_REQ, "fetch_timeout_wait");
    for (int i = 0; i < 5; i++)
      step(rbit(), 7'($urandom), rbit(), B_HALT | B_BERR, "bus_timeout_halt");

    do_reset();
    for (int i = 0; i < TO; i++)
      step(1'b0, 7'($urandom), rbit(), B_REQ, "mem_timeout_fetch");
    step(1'b0, 7'($urandom), rbit(), B_HALT | B_BERR, "fetch_timeout_no_ack_halt");

    do_reset();
    run_instr(7'b0000011, 0, 0, 1'b0);
    s_regwe = 0;
    step(1'b1, 7'h00, 1'b0, B_REQ | B_IR | B_PCWE, "st_fetch");
    step(1'b0, 7'b0100011, 1'b0, 14'h0, "st_decode");
    step(1'b0, 7'h00, 1'b0, B_ALUSRC, "st_exec");
    for (int i = 0; i < TO - 1; i++)
      step(1'b0, 7'h00, 1'b0, B_REQ | B_SEL | B_WE, "st_mem_wait");
    bus.mem_ack = 1'b0;
    @(negedge clk);
    chk_vec(dut_vec(), B_REQ | B_SEL | B_WE, "st_mem_last_wait");
    #1;
    rst_n = 1'b0;
    #1;
    chk_int(bus.mem_req, 0, "async_req_drop");
    chk_vec(dut_vec(), 14'h0, "async_outputs_zero");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1'b1, 7'h00, 1'b0, 14'h0, "rst_after_abort");
    step(1'b1, 7'h00, 1'b0, B_REQ | B_IR | B_PCWE, "fetch_after_abort");
`ifdef CTRL_PERF_CNT_EN
    chk_int(instret, 0, "instret_cleared");
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
